// File: rtl/sift_pkg.sv
// Shared SIFT keypoint types: entry layout, output word kinds, streamer FSM states.
package sift_pkg;
  localparam int KPT_ROW_W  = 9;
  localparam int KPT_COL_W  = 10;
  localparam int KPT_ADDR_W = 10;
  localparam logic [KPT_ADDR_W:0] KPT_MAX = (KPT_ADDR_W+1)'(1 << KPT_ADDR_W);

  typedef struct packed {
    logic [KPT_ROW_W-1:0] row;
    logic [KPT_COL_W-1:0] col;
  } kpt_entry_t;

  typedef enum logic [1:0] {W_HDR, W_ROW, W_COL, W_CSUM} word_t;

  typedef enum logic [3:0] {
    S_IDLE, S_HDR1, S_FETCH1, S_LATCH1, S_ROW1, S_COL1,
    S_HDR2, S_FETCH2, S_LATCH2, S_ROW2, S_COL2, S_CSUM, S_DONE
  } kst_t;

  function automatic logic [KPT_ADDR_W:0] clamp_num(input logic [KPT_ADDR_W:0] n);
    return (n > KPT_MAX) ? KPT_MAX : n;
  endfunction

  function automatic logic [15:0] fmt_word(input word_t t, input logic layer,
                                           input kpt_entry_t e,
                                           input logic [KPT_ADDR_W:0] num,
                                           input logic [15:0] csum);
    case (t)
      W_HDR:   return {5'b0, num};
      W_ROW:   return {layer, 6'b0, e.row};
      W_COL:   return {6'b0, e.col};
      default: return csum;
    endcase
  endfunction
endpackage

// File: rtl/kpt_layer_reader.sv
// Per-layer keypoint memory reader: index counter, read strobe, entry latch.
module kpt_layer_reader
  import sift_pkg::*;
#(
  parameter int ADDR_W = KPT_ADDR_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_clr,
  input  logic                           i_fetch,
  input  logic                           i_latch,
  input  logic                           i_inc,
  input  logic [ADDR_W:0]                i_num,
  input  logic [KPT_ROW_W+KPT_COL_W-1:0] i_rd_data,
  output logic                           o_rd_en,
  output logic [ADDR_W-1:0]              o_rd_addr,
  output kpt_entry_t                     o_rd_entry,
  output kpt_entry_t                     o_entry,
  output logic                           o_last
);
  logic [ADDR_W-1:0] r_idx;
  kpt_entry_t        r_entry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_entry <= '0;
    end else begin
      if (i_clr)      r_idx <= '0;
      else if (i_inc) r_idx <= r_idx + 1'b1;
      if (i_latch)    r_entry <= kpt_entry_t'(i_rd_data);
    end
  end

  assign o_rd_en    = i_fetch;
  assign o_rd_addr  = r_idx;
  assign o_rd_entry = kpt_entry_t'(i_rd_data);
  assign o_entry    = r_entry;
  // 11-bit compare so a full 1024-entry layer terminates despite the 10-bit index
  assign o_last     = (({1'b0, r_idx} + (ADDR_W+1)'(1)) == i_num);
endmodule

// File: rtl/kpt_output_streamer.sv
// Streams both keypoint layers onto the 16-bit valid/ready output bus.
// Define KPT_OUT_CHECKSUM_EN to append an XOR trailer word after layer 2.
module kpt_output_streamer
  import sift_pkg::*;
#(
  parameter int ADDR_W = KPT_ADDR_W,
  parameter int ROW_W  = KPT_ROW_W,
  parameter int COL_W  = KPT_COL_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_W:0]        kp1_num,
  input  logic [ADDR_W:0]        kp2_num,
  output logic                   kp1_rd_en,
  output logic [ADDR_W-1:0]      kp1_rd_addr,
  input  logic [ROW_W+COL_W-1:0] kp1_rd_data,
  output logic                   kp2_rd_en,
  output logic [ADDR_W-1:0]      kp2_rd_addr,
  input  logic [ROW_W+COL_W-1:0] kp2_rd_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [15:0]            out_data,
  output logic                   busy,
  output logic                   done
);
  kst_t            r_state;
  logic [ADDR_W:0] r_num1, r_num2;
  logic            r_out_valid, r_busy, r_done;
  logic [15:0]     r_out_data;
  logic            w_xfer, w_clr, w_last1, w_last2, w_l2_end;
  kpt_entry_t      w_rd1, w_rd2, w_ent1, w_ent2;
  logic [ADDR_W:0] w_n1c, w_n2c;

  assign w_xfer   = r_out_valid && out_ready;
  assign w_clr    = (r_state == S_IDLE) && start;
  assign w_n1c    = clamp_num(kp1_num);
  assign w_n2c    = clamp_num(kp2_num);
  assign w_l2_end = w_xfer && (((r_state == S_HDR2) && (r_num2 == '0)) ||
                               ((r_state == S_COL2) && w_last2));

  kpt_layer_reader #(.ADDR_W(ADDR_W)) u_rd1 (
    .clk(clk), .rst(rst), .i_clr(w_clr),
    .i_fetch(r_state == S_FETCH1), .i_latch(r_state == S_LATCH1),
    .i_inc((r_state == S_COL1) && w_xfer), .i_num(r_num1), .i_rd_data(kp1_rd_data),
    .o_rd_en(kp1_rd_en), .o_rd_addr(kp1_rd_addr), .o_rd_entry(w_rd1),
    .o_entry(w_ent1), .o_last(w_last1)
  );

  kpt_layer_reader #(.ADDR_W(ADDR_W)) u_rd2 (
    .clk(clk), .rst(rst), .i_clr(w_clr),
    .i_fetch(r_state == S_FETCH2), .i_latch(r_state == S_LATCH2),
    .i_inc((r_state == S_COL2) && w_xfer), .i_num(r_num2), .i_rd_data(kp2_rd_data),
    .o_rd_en(kp2_rd_en), .o_rd_addr(kp2_rd_addr), .o_rd_entry(w_rd2),
    .o_entry(w_ent2), .o_last(w_last2)
  );

`ifdef KPT_OUT_CHECKSUM_EN
  logic [15:0] r_csum;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_csum <= '0;
    else if (w_clr)  r_csum <= '0;
    else if (w_xfer) r_csum <= r_csum ^ r_out_data;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_num1      <= '0;
      r_num2      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_num1      <= w_n1c;
          r_num2      <= w_n2c;
          r_busy      <= 1'b1;
          r_out_valid <= 1'b1;
          r_out_data  <= fmt_word(W_HDR, 1'b0, '0, w_n1c, '0);
          r_state     <= S_HDR1;
        end
        S_HDR1: if (w_xfer) begin
          if (r_num1 == '0) begin
            r_out_data <= fmt_word(W_HDR, 1'b0, '0, r_num2, '0);
            r_state    <= S_HDR2;
          end else begin
            r_out_valid <= 1'b0;
            r_state     <= S_FETCH1;
          end
        end
        S_FETCH1: r_state <= S_LATCH1;
        // read data is live this cycle, so the row word is built straight from it
        S_LATCH1: begin
          r_out_valid <= 1'b1;
          r_out_data  <= fmt_word(W_ROW, 1'b0, w_rd1, '0, '0);
          r_state     <= S_ROW1;
        end
        S_ROW1: if (w_xfer) begin
          r_out_data <= fmt_word(W_COL, 1'b0, w_ent1, '0, '0);
          r_state    <= S_COL1;
        end
        S_COL1: if (w_xfer) begin
          if (w_last1) begin
            r_out_data <= fmt_word(W_HDR, 1'b0, '0, r_num2, '0);
            r_state    <= S_HDR2;
          end else begin
            r_out_valid <= 1'b0;
            r_state     <= S_FETCH1;
          end
        end
        S_HDR2: if (w_xfer && (r_num2 != '0)) begin
          r_out_valid <= 1'b0;
          r_state     <= S_FETCH2;
        end
        S_FETCH2: r_state <= S_LATCH2;
        S_LATCH2: begin
          r_out_valid <= 1'b1;
          r_out_data  <= fmt_word(W_ROW, 1'b1, w_rd2, '0, '0);
          r_state     <= S_ROW2;
        end
        S_ROW2: if (w_xfer) begin
          r_out_data <= fmt_word(W_COL, 1'b1, w_ent2, '0, '0);
          r_state    <= S_COL2;
        end
        S_COL2: if (w_xfer && !w_last2) begin
          r_out_valid <= 1'b0;
          r_state     <= S_FETCH2;
        end
        S_CSUM: if (w_xfer) begin
          r_out_valid <= 1'b0;
          r_done      <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_l2_end) begin
`ifdef KPT_OUT_CHECKSUM_EN
        // trailer folds in the word transferring right now
        r_out_data <= fmt_word(W_CSUM, 1'b0, '0, '0, r_csum ^ r_out_data);
        r_state    <= S_CSUM;
`else
        r_out_valid <= 1'b0;
        r_done      <= 1'b1;
        r_state     <= S_DONE;
`endif
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;
  assign done      = r_done;
endmodule

// File: tb/tb_kpt_output_streamer.sv
// Randomized bench for kpt_output_streamer against a word-list reference model.
module tb_kpt_output_streamer;
  logic        clk = 1'b0;
  logic        rst, start, out_ready;
  logic [10:0] kp1_num, kp2_num;
  logic        kp1_rd_en, kp2_rd_en;
  logic [9:0]  kp1_rd_addr, kp2_rd_addr;
  logic [18:0] kp1_rd_data = '0, kp2_rd_data = '0;
  logic        out_valid, busy, done;
  logic [15:0] out_data;

  logic [18:0] mem1 [1024];
  logic [18:0] mem2 [1024];
  logic [15:0] exp_q [$];
  logic [15:0] got_q [$];
  int n_vec = 0, n_err = 0, n_rd = 0;

  kpt_output_streamer dut (
    .clk(clk), .rst(rst), .start(start), .kp1_num(kp1_num), .kp2_num(kp2_num),
    .kp1_rd_en(kp1_rd_en), .kp1_rd_addr(kp1_rd_addr), .kp1_rd_data(kp1_rd_data),
    .kp2_rd_en(kp2_rd_en), .kp2_rd_addr(kp2_rd_addr), .kp2_rd_data(kp2_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // memory model: data appears the cycle after the strobe
  always @(posedge clk) begin
    if (kp1_rd_en) kp1_rd_data <= mem1[kp1_rd_addr];
    if (kp2_rd_en) kp2_rd_data <= mem2[kp2_rd_addr];
    if (kp1_rd_en || kp2_rd_en) n_rd <= n_rd + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  function automatic int clampn(input int n);
    return (n > 1024) ? 1024 : n;
  endfunction

  task automatic build_exp(input int n1, input int n2);
    int c1, c2, x;
    c1 = clampn(n1);
    c2 = clampn(n2);
    exp_q.delete();
    exp_q.push_back(16'(c1));
    for (int i = 0; i < c1; i++) begin
      exp_q.push_back(16'(mem1[i] / 1024));
      exp_q.push_back(16'(mem1[i] % 1024));
    end
    exp_q.push_back(16'(c2));
    for (int i = 0; i < c2; i++) begin
      exp_q.push_back(16'(32768 + mem2[i] / 1024));
      exp_q.push_back(16'(mem2[i] % 1024));
    end
`ifdef KPT_OUT_CHECKSUM_EN
    x = 0;
    foreach (exp_q[i]) x = x ^ int'(exp_q[i]);
    exp_q.push_back(16'(x));
`endif
  endtask

  // mode: 0 ready high, 1 random ready, 2 ready pattern 1,0,0,1
  task automatic run(input int n1, input int n2, input int mode, input bit restart, input bit abort);
    int  budget, cyc, rd0, busy_bad, tog, nchk;
    bit  fin, pulsed, prev_stall;
    logic [15:0] prev_d;
    budget = 20 * (clampn(n1) + clampn(n2)) + 100;
    cyc = 0; busy_bad = 0; tog = 0; fin = 0; pulsed = 0; prev_stall = 0; prev_d = '0;
    build_exp(n1, n2);
    got_q.delete();
    @(negedge clk);
    rd0 = n_rd;
    kp1_num = 11'(n1); kp2_num = 11'(n2); start = 1'b1;
    while (!fin && cyc < budget) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (restart && got_q.size() == 3 && !pulsed) begin
        start = 1'b1; pulsed = 1;
      end
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin out_ready = (tog % 4 == 0) || (tog % 4 == 3); tog++; end
      endcase
      #1;
      if (abort && got_q.size() == 1 && out_valid) begin
        rst = 1'b1;
        #1;
        chk("abort_valid", 32'(out_valid), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_data", 32'(out_data), 0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (prev_stall) begin
        chk("hold_data", 32'(out_data), 32'(prev_d));
        chk("hold_valid", 32'(out_valid), 1);
      end
      if (done) fin = 1;
      else begin
        if (!busy) busy_bad++;
        if (out_valid && out_ready) got_q.push_back(out_data);
        prev_stall = out_valid && !out_ready;
        prev_d = out_data;
      end
    end
    start = 1'b0;
    if (!fin) chk("timeout", 0, 1);
    chk("busy_during", 32'(busy_bad), 0);
    chk("nwords", 32'(got_q.size()), 32'(exp_q.size()));
    nchk = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < nchk; i++) chk($sformatf("word%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    chk("nreads", 32'(n_rd - rd0), 32'(clampn(n1) + clampn(n2)));
    @(negedge clk);
    #1;
    chk("busy_after", 32'(busy), 0);
    chk("done_pulse", 32'(done), 0);
  endtask

  task automatic load_scn1();
    mem1[0] = {9'd5, 10'd7};
    mem1[1] = {9'd479, 10'd639};
    mem2[0] = {9'd0, 10'd1};
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b1; kp1_num = '0; kp2_num = '0;
    for (int i = 0; i < 1024; i++) begin
      mem1[i] = 19'($urandom);
      mem2[i] = 19'($urandom);
    end
    #2;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_rd1", {kp1_rd_en, 21'd0, kp1_rd_addr}, 0);
    chk("rst_rd2", {kp2_rd_en, 21'd0, kp2_rd_addr}, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    @(negedge clk);
    rst = 1'b0;

    load_scn1();
    run(2, 1, 0, 0, 0);
    run(0, 0, 0, 0, 0);
    run(2, 1, 2, 0, 0);
    run(2, 1, 0, 1, 0);
    run(2, 1, 0, 0, 1);
    run(2, 1, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 32; i++) begin
        mem1[i] = 19'($urandom);
        mem2[i] = 19'($urandom);
      end
      run(int'($urandom_range(0, 12)), int'($urandom_range(0, 12)), int'($urandom_range(0, 2)), 0, 0);
    end
    run(1100, 3, 0, 0, 0);
    run(0, 4, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/kpt_output_streamer.md
Name: kpt_output_streamer

Overview:
- Drains the two keypoint memories (layer 1, layer 2) after keypoint detection/filtering finishes.
- Serialises each memory onto the 16-bit core output bus with a valid/ready handshake.
- Sits directly downstream of the detect-filter stage; its output drives the core's out_valid/out_data.
- Entry format from the keypoint memories is 19 bits: row[18:10] (9 b), col[9:0] (10 b).

Parameters:
ADDR_W, 10, keypoint memory address width (max 1024 entries per layer)
ROW_W, 9, row field width
COL_W, 10, column field width

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse from detect-filter done
kp1_num  in  ADDR_W+1  layer-1 entry count (0..1024), sampled on start
kp2_num  in  ADDR_W+1  layer-2 entry count, sampled on start
kp1_rd_en  out  1  layer-1 memory read strobe
kp1_rd_addr  out  ADDR_W  layer-1 read address
kp1_rd_data  in  ROW_W+COL_W  layer-1 entry, valid the cycle after kp1_rd_en
kp2_rd_en / kp2_rd_addr / kp2_rd_data  same as above, for layer 2
out_valid  out  1  output word valid
out_ready  in  1  downstream accepts the word
out_data  out  16  output word
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse after the final word is accepted

Interface (decided):
- One clock, clk.
- Reset rst is asynchronous and active-high. It clears every register immediately.

Behaviour:
- Reset values: out_valid=0, out_data=0, kp*_rd_en=0, kp*_rd_addr=0, busy=0, done=0, FSM=IDLE.
- Reset asserted mid-stream aborts the stream. There is no resume.
- FSM: IDLE -> HDR1 -> {FETCH1 -> LATCH1 -> ROW1 -> COL1}×kp1_num -> HDR2 -> {FETCH2 -> LATCH2 -> ROW2 -> COL2}×kp2_num -> [CSUM] -> DONE -> IDLE.
- IDLE: start=1 registers kp1_num and kp2_num, clears the index, and moves to HDR1. Inputs are clamped to 1024 if larger.
- start while busy is ignored.
- Header word: {5'b0, num[10:0]}. HDR1 carries layer 1, HDR2 carries layer 2.
- FETCH: rd_en=1 for exactly one cycle with rd_addr=idx.
- LATCH: captures rd_data into the entry register.
- ROW word: {layer_bit, 6'b0, row[8:0]}. layer_bit=0 for layer 1, 1 for layer 2.
- COL word: {6'b0, col[9:0]}.
- Handshake:
  - A word transfers when out_valid && out_ready.
  - out_data and out_valid are registered and held stable while out_valid && !out_ready.
  - out_valid is high only in HDR, ROW, COL and CSUM states.
  - Each of those states advances only on a transfer.
- COLn on transfer: idx+1. If idx+1 == num, go to the next header or the end; otherwise go to FETCHn.
- num=0 for a layer: the header word is sent, then the FSM skips directly to the next phase. No reads are issued.
- Both counts 0: exactly two words are sent (0x0000, 0x0000), then done.
- Throughput with out_ready tied high: one keypoint per 4 cycles (2 words).
- DONE: done=1 for one cycle, busy=0 on the next cycle, FSM returns to IDLE.
- A start in the DONE cycle is ignored.
- Total words = 2 + 2·(kp1_num + kp2_num), plus 1 with the optional feature.

Optional Feature:
- Macro: KPT_OUT_CHECKSUM_EN.
- Defined:
  - A 16-bit running XOR of every transferred word is kept; it is cleared on start.
  - After the last layer-2 word, state CSUM emits one trailer word equal to the XOR, with the same handshake.
  - done follows the trailer's transfer.
- Undefined: no CSUM state, no accumulator. done follows the last COL2 (or HDR2) transfer.

Decomposition:
- Shared package sift_pkg holds:
  - KPT_ROW_W=9, KPT_COL_W=10, KPT_ADDR_W=10.
  - Keypoint entry struct {row, col}.
  - Output word-type enum (HDR, ROW, COL, CSUM).
  - State enum for this FSM.
- One sub-module is natural: kpt_layer_reader (FETCH/LATCH/index counter), instantiated twice and muxed by the top FSM.

Test Plan:
- kp1_num=2 with entries {row=5,col=7},{row=479,col=639}; kp2_num=1 with {row=0,col=1}; out_ready=1 -> out_data sequence 0x0002, 0x0005, 0x0007, 0x01DF, 0x027F, 0x0001, 0x8000, 0x0001, then done. busy high for the whole stream.
- Both counts 0 -> exactly 0x0000, 0x0000, then a done pulse. kp*_rd_en never asserted.
- Same stream as the first test with out_ready toggling 1,0,0,1 -> word order unchanged. out_data held constant through the stall cycles. No word dropped or duplicated.
- start pulsed again mid-stream (after 3 words) -> ignored; total word count stays 8.
- rst asserted while in ROW1 -> out_valid=0, busy=0 asynchronously. A new start afterwards restarts from HDR1 (0x0002).
- KPT_OUT_CHECKSUM_EN defined, first scenario -> a 9th word equal to the XOR of the 8 words, then done.
